// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types for the register-file writeback arbiter.
// Defines default widths, the writeback request record and the source encoding.
package rf_wb_pkg;

   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned DEF_REG_W  = 5;

   typedef struct packed {
      logic [DEF_REG_W-1:0]  rd;
      logic [DEF_DATA_W-1:0] data;
   } wb_req_t;

   typedef enum logic {
      WB_SRC_ALU = 1'b0,
      WB_SRC_MEM = 1'b1
   } wb_src_e;

endpackage

// File: rtl/rf_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter.
// req[0]/gnt[0] is the ALU source, req[1]/gnt[1] is the load source.
// On a tie the source not named by last_grant wins; stall suppresses all grants.
module rr_arb2
   import rf_wb_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       stall,
   output logic [1:0] gnt
);

   wb_src_e last_grant;

   // Grant decode: single requester wins outright, tie goes to the other source.
   always_comb begin
      gnt = '0;
      if (!stall) begin
         if (req == 2'b11) begin
            gnt = (last_grant == WB_SRC_MEM) ? 2'b01 : 2'b10;
         end else begin
            gnt = req;
         end
      end
   end

   // Remember the most recent winner; held while nothing is granted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= WB_SRC_MEM;
      end else if (gnt[0]) begin
         last_grant <= WB_SRC_ALU;
      end else if (gnt[1]) begin
         last_grant <= WB_SRC_MEM;
      end
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: merges ALU and load writebacks onto the
// single RF write port through one output register stage.
// Optional macro RF_WB_BYPASS_EN adds two decode-read bypass ports that see
// the in-flight write in the same cycle.
module rf_wb_arbiter
   import rf_wb_pkg::*;
#(
   parameter int unsigned DATA_W  = DEF_DATA_W,
   parameter int unsigned REG_W   = DEF_REG_W,
   parameter int unsigned DROP_R0 = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              alu_wb_valid,
   input  logic [REG_W-1:0]  alu_wb_reg,
   input  logic [DATA_W-1:0] alu_wb_data,
   output logic              alu_wb_ready,
   input  logic              mem_wb_valid,
   input  logic [REG_W-1:0]  mem_wb_reg,
   input  logic [DATA_W-1:0] mem_wb_data,
   output logic              mem_wb_ready,
   input  logic              wb_stall,
`ifdef RF_WB_BYPASS_EN
   input  logic [REG_W-1:0]  rd1_sel,
   input  logic [REG_W-1:0]  rd2_sel,
   output logic              fwd1_hit,
   output logic              fwd2_hit,
   output logic [DATA_W-1:0] fwd1_data,
   output logic [DATA_W-1:0] fwd2_data,
`endif
   output logic              rf_write,
   output logic [REG_W-1:0]  rf_writeregsel,
   output logic [DATA_W-1:0] rf_writedata,
   output logic              conflict_err
);

   logic [1:0]        req;
   logic [1:0]        gnt;
   logic [REG_W-1:0]  sel_reg;
   logic [DATA_W-1:0] sel_data;
   logic              xfer;
   logic              drop;
   logic              collide;

   assign req = {mem_wb_valid, alu_wb_valid};

   rr_arb2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .stall (wb_stall),
      .gnt   (gnt)
   );

   assign alu_wb_ready = gnt[0];
   assign mem_wb_ready = gnt[1];

   // Select the granted source and classify the transfer.
   always_comb begin
      sel_reg  = alu_wb_reg;
      sel_data = alu_wb_data;
      if (gnt[1]) begin
         sel_reg  = mem_wb_reg;
         sel_data = mem_wb_data;
      end
      xfer    = |gnt;
      drop    = (DROP_R0 != 0) && (sel_reg == '0);
      collide = (&req) && !wb_stall && (alu_wb_reg == mem_wb_reg);
   end

   // Output register stage; a dropped r0 write leaves index/data untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_write       <= 1'b0;
         rf_writeregsel <= '0;
         rf_writedata   <= '0;
      end else begin
         rf_write <= xfer && !drop;
         if (xfer && !drop) begin
            rf_writeregsel <= sel_reg;
            rf_writedata   <= sel_data;
         end
      end
   end

   // Sticky same-register collision flag, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         conflict_err <= 1'b0;
      end else if (collide) begin
         conflict_err <= 1'b1;
      end
   end

`ifdef RF_WB_BYPASS_EN
   assign fwd1_hit  = rf_write && (rd1_sel == rf_writeregsel) && (rf_writeregsel != '0);
   assign fwd2_hit  = rf_write && (rd2_sel == rf_writeregsel) && (rf_writeregsel != '0);
   assign fwd1_data = rf_writedata;
   assign fwd2_data = rf_writedata;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios followed by
// constrained-random traffic compared against a rule-level reference model.
module tb_rf_wb_arbiter;

   logic        clk;
   logic        rst_n;
   logic        alu_wb_valid;
   logic [4:0]  alu_wb_reg;
   logic [31:0] alu_wb_data;
   logic        alu_wb_ready;
   logic        mem_wb_valid;
   logic [4:0]  mem_wb_reg;
   logic [31:0] mem_wb_data;
   logic        mem_wb_ready;
   logic        wb_stall;
   logic        rf_write;
   logic [4:0]  rf_writeregsel;
   logic [31:0] rf_writedata;
   logic        conflict_err;
`ifdef RF_WB_BYPASS_EN
   logic [4:0]  rd1_sel;
   logic [4:0]  rd2_sel;
   logic        fwd1_hit;
   logic        fwd2_hit;
   logic [31:0] fwd1_data;
   logic [31:0] fwd2_data;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model state: who won the last transfer, expected outputs.
   bit          m_last_mem;
   bit          m_write;
   logic [4:0]  m_reg;
   logic [31:0] m_data;
   bit          m_conf;

   // Readies observed in the most recent cycle().
   logic obs_alu_rdy;
   logic obs_mem_rdy;

   rf_wb_arbiter #(.DATA_W(32), .REG_W(5), .DROP_R0(1)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .alu_wb_valid   (alu_wb_valid),
      .alu_wb_reg     (alu_wb_reg),
      .alu_wb_data    (alu_wb_data),
      .alu_wb_ready   (alu_wb_ready),
      .mem_wb_valid   (mem_wb_valid),
      .mem_wb_reg     (mem_wb_reg),
      .mem_wb_data    (mem_wb_data),
      .mem_wb_ready   (mem_wb_ready),
      .wb_stall       (wb_stall),
`ifdef RF_WB_BYPASS_EN
      .rd1_sel        (rd1_sel),
      .rd2_sel        (rd2_sel),
      .fwd1_hit       (fwd1_hit),
      .fwd2_hit       (fwd2_hit),
      .fwd1_data      (fwd1_data),
      .fwd2_data      (fwd2_data),
`endif
      .rf_write       (rf_write),
      .rf_writeregsel (rf_writeregsel),
      .rf_writedata   (rf_writedata),
      .conflict_err   (conflict_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_last_mem = 1'b1;
      m_write    = 1'b0;
      m_reg      = '0;
      m_data     = '0;
      m_conf     = 1'b0;
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, "_wr"},   {31'd0, rf_write},       {31'd0, m_write});
      chk({tag, "_reg"},  {27'd0, rf_writeregsel}, {27'd0, m_reg});
      chk({tag, "_data"}, rf_writedata,            m_data);
      chk({tag, "_conf"}, {31'd0, conflict_err},   {31'd0, m_conf});
   endtask

   // Asynchronous reset in mid-cycle; outputs must clear before any edge.
   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      #1;
      alu_wb_valid = 1'b0;
      mem_wb_valid = 1'b0;
      wb_stall     = 1'b0;
      model_reset();
      check_outputs("rst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // One clock: check readies against the arbitration rules, then outputs after the edge.
   task automatic cycle(input string tag);
      bit ea, em;
      bit nw, nc;
      logic [4:0]  nr;
      logic [31:0] nd;
      #1;
      ea = !wb_stall && alu_wb_valid && (!mem_wb_valid || m_last_mem);
      em = !wb_stall && mem_wb_valid && (!alu_wb_valid || !m_last_mem);
      obs_alu_rdy = alu_wb_ready;
      obs_mem_rdy = mem_wb_ready;
      chk({tag, "_ardy"}, {31'd0, alu_wb_ready}, {31'd0, ea});
      chk({tag, "_mrdy"}, {31'd0, mem_wb_ready}, {31'd0, em});
      nw = 1'b0;
      nr = m_reg;
      nd = m_data;
      if (ea || em) begin
         logic [4:0]  r;
         logic [31:0] d;
         r = ea ? alu_wb_reg  : mem_wb_reg;
         d = ea ? alu_wb_data : mem_wb_data;
         if (r != 5'd0) begin
            nw = 1'b1;
            nr = r;
            nd = d;
         end
      end
      nc = m_conf || (alu_wb_valid && mem_wb_valid && !wb_stall && alu_wb_reg == mem_wb_reg);
      @(posedge clk);
      #1;
      if (ea) m_last_mem = 1'b0;
      if (em) m_last_mem = 1'b1;
      m_write = nw;
      m_reg   = nr;
      m_data  = nd;
      m_conf  = nc;
      check_outputs(tag);
   endtask

   initial begin
      bit alu_hold, mem_hold;
      rst_n        = 1'b0;
      alu_wb_valid = 1'b0;
      alu_wb_reg   = '0;
      alu_wb_data  = '0;
      mem_wb_valid = 1'b0;
      mem_wb_reg   = '0;
      mem_wb_data  = '0;
      wb_stall     = 1'b0;
`ifdef RF_WB_BYPASS_EN
      rd1_sel = '0;
      rd2_sel = '0;
`endif
      model_reset();
      #3;
      check_outputs("init");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // ALU-only write lands one cycle later.
      alu_wb_valid = 1'b1; alu_wb_reg = 5'd5; alu_wb_data = 32'hDEADBEEF;
      cycle("t1");
      chk("t1_rdy_const",  {31'd0, obs_alu_rdy}, 32'd1);
      chk("t1_wr_const",   {31'd0, rf_write}, 32'd1);
      chk("t1_reg_const",  {27'd0, rf_writeregsel}, 32'd5);
      chk("t1_data_const", rf_writedata, 32'hDEADBEEF);
      alu_wb_valid = 1'b0;
      cycle("t1_idle");

      // Both sources every cycle after reset: strict alternation starting with ALU.
      do_reset();
      alu_wb_valid = 1'b1; alu_wb_reg = 5'd3; alu_wb_data = 32'h0000_0A03;
      mem_wb_valid = 1'b1; mem_wb_reg = 5'd4; mem_wb_data = 32'h0000_0B04;
      for (int i = 0; i < 4; i++) begin
         cycle("t2");
         chk("t2_alu_gnt", {31'd0, obs_alu_rdy}, (i % 2 == 0) ? 32'd1 : 32'd0);
         chk("t2_wr_nogap", {31'd0, rf_write}, 32'd1);
         chk("t2_reg_seq", {27'd0, rf_writeregsel}, (i % 2 == 0) ? 32'd3 : 32'd4);
      end

      // Stall blocks everything, then round-robin picks up where it left off.
      wb_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle("t3_stall");
         chk("t3_stall_rdy", {30'd0, obs_alu_rdy, obs_mem_rdy}, 32'd0);
         chk("t3_stall_wr", {31'd0, rf_write}, 32'd0);
      end
      wb_stall = 1'b0;
      cycle("t3_rel0");
      chk("t3_rel0_alu", {31'd0, obs_alu_rdy}, 32'd1);
      cycle("t3_rel1");
      chk("t3_rel1_mem", {31'd0, obs_mem_rdy}, 32'd1);

      // Load to r0 completes the handshake but never writes.
      alu_wb_valid = 1'b0;
      mem_wb_valid = 1'b1; mem_wb_reg = 5'd0; mem_wb_data = 32'h0000_1234;
      cycle("t4");
      chk("t4_mrdy_const", {31'd0, obs_mem_rdy}, 32'd1);
      chk("t4_wr_const",   {31'd0, rf_write}, 32'd0);
      mem_wb_valid = 1'b0;

      // Same-register collision sets a sticky flag; async reset clears it.
      alu_wb_valid = 1'b1; alu_wb_reg = 5'd7; alu_wb_data = 32'h7777_0001;
      mem_wb_valid = 1'b1; mem_wb_reg = 5'd7; mem_wb_data = 32'h7777_0002;
      cycle("t5");
      chk("t5_conf_set", {31'd0, conflict_err}, 32'd1);
      alu_wb_valid = 1'b0;
      cycle("t5_hold");
      chk("t5_conf_hold", {31'd0, conflict_err}, 32'd1);
      do_reset();

`ifdef RF_WB_BYPASS_EN
      alu_wb_valid = 1'b1; alu_wb_reg = 5'd9; alu_wb_data = 32'h0000_0055;
      mem_wb_valid = 1'b0;
      rd1_sel = 5'd3; rd2_sel = 5'd9;
      cycle("t6");
      chk("t6_fwd2_hit",  {31'd0, fwd2_hit}, 32'd1);
      chk("t6_fwd2_data", fwd2_data, 32'h0000_0055);
      chk("t6_fwd1_hit",  {31'd0, fwd1_hit}, 32'd0);
      alu_wb_valid = 1'b0;
      cycle("t6_idle");
      chk("t6_fwd2_gone", {31'd0, fwd2_hit}, 32'd0);
`endif

      // Random traffic obeying the hold-until-ready rule, with one mid-run reset.
      alu_hold = 1'b0;
      mem_hold = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (i == 200) begin
            do_reset();
            alu_hold = 1'b0;
            mem_hold = 1'b0;
         end
         if (!alu_hold) begin
            alu_wb_valid = ($urandom_range(0, 3) != 0);
            alu_wb_reg   = 5'($urandom_range(0, 7));
            alu_wb_data  = $urandom;
         end
         if (!mem_hold) begin
            mem_wb_valid = ($urandom_range(0, 3) != 0);
            mem_wb_reg   = 5'($urandom_range(0, 7));
            mem_wb_data  = $urandom;
         end
         wb_stall = ($urandom_range(0, 4) == 0);
         cycle("rnd");
         alu_hold = alu_wb_valid && !obs_alu_rdy;
         mem_hold = mem_wb_valid && !obs_mem_rdy;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
